// File: rtl/mc8051_mem_if_pkg.sv
// mc8051_mem_if_pkg: address-space codes and sequencer state encoding
package mc8051_mem_if_pkg;

    localparam logic [1:0] MEM_SP_IRAM = 2'd0;
    localparam logic [1:0] MEM_SP_SFR  = 2'd1;
    localparam logic [1:0] MEM_SP_XRAM = 2'd2;
    localparam logic [1:0] MEM_SP_CODE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR5,
        ST_RD2,
        ST_RD3,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mc8051_mem_slot.sv
// mc8051_mem_slot: one pending request slot (flag, space, address) with overwrite detect
module mc8051_mem_slot
    import mc8051_mem_if_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [1:0]        space_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              pend_o,
    output logic [1:0]        space_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o
);

    logic              pend_q;
    logic [1:0]        space_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // IRAM/SFR (space bit 1 clear) only use the low byte
    assign addr_d  = addr_i & {{(ADDR_W-8){space_i[1]}}, 8'hFF};
    assign err_o   = set_i && pend_q && !clr_i;
    assign pend_o  = pend_q;
    assign space_o = space_q;
    assign addr_o  = addr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q  <= 1'b0;
            space_q <= MEM_SP_IRAM;
            addr_q  <= '0;
        end else if (set_i) begin
            pend_q  <= 1'b1;
            space_q <= space_i;
            addr_q  <= addr_d;
        end else if (clr_i) begin
            pend_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/mc8051_mem_if.sv
// mc8051_mem_if: serialises S5 write and S2/S3 reads onto one ready-handshaked bus,
// with read-after-write forwarding, timeout abort and pipeline stall.
module mc8051_mem_if
    import mc8051_mem_if_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_s2_rd,
    input  logic [1:0]        i_s2_space,
    input  logic [ADDR_W-1:0] i_s2_mem_addr_d,
    input  logic              i_s3_rd,
    input  logic [1:0]        i_s3_space,
    input  logic [ADDR_W-1:0] i_s3_mem_addr_d,
    input  logic              i_s5_wr,
    input  logic [1:0]        i_s5_space,
    input  logic [ADDR_W-1:0] i_s5_mem_addr_d,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [1:0]        o_mem_space,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic [DATA_W-1:0] o_s2_data_buffer,
    output logic [DATA_W-1:0] o_s3_data_buffer,
    output logic              o_stall,
    output logic              o_bus_err
);

    state_t            state_q;
    logic [7:0]        wait_q;
    logic [DATA_W-1:0] wd5_q;
    logic              p5, p2, p3, e5, e2, e3, clr5, clr2, clr3;
    logic [1:0]        sp5, sp2, sp3;
    logic [ADDR_W-1:0] a5, a2, a3;
    logic              idle, code5, hit2, hit3, timeout, acc_end;

    mc8051_mem_slot #(.ADDR_W(ADDR_W)) u_s5 (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .set_i(i_s5_wr), .clr_i(clr5),
        .space_i(i_s5_space), .addr_i(i_s5_mem_addr_d),
        .pend_o(p5), .space_o(sp5), .addr_o(a5), .err_o(e5)
    );

    mc8051_mem_slot #(.ADDR_W(ADDR_W)) u_s2 (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .set_i(i_s2_rd), .clr_i(clr2),
        .space_i(i_s2_space), .addr_i(i_s2_mem_addr_d),
        .pend_o(p2), .space_o(sp2), .addr_o(a2), .err_o(e2)
    );

    mc8051_mem_slot #(.ADDR_W(ADDR_W)) u_s3 (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .set_i(i_s3_rd), .clr_i(clr3),
        .space_i(i_s3_space), .addr_i(i_s3_mem_addr_d),
        .pend_o(p3), .space_o(sp3), .addr_o(a3), .err_o(e3)
    );

    assign idle    = state_q == ST_IDLE;
    assign code5   = p5 && sp5 == MEM_SP_CODE;
    assign hit2    = p5 && !code5 && p2 && sp2 == sp5 && a2 == a5;
    assign hit3    = p5 && !code5 && p3 && sp3 == sp5 && a3 == a5;
    assign timeout = wait_q == 8'(WAIT_MAX - 1);
    assign acc_end = i_mem_ready || timeout;
    assign clr5    = (idle && code5) || (state_q == ST_WR5 && acc_end);
    assign clr2    = (idle && hit2) || (state_q == ST_RD2 && acc_end);
    assign clr3    = (idle && !hit2 && hit3) || (state_q == ST_RD3 && acc_end);
    assign o_stall = p5 || p2 || p3 || !idle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd5_q <= '0;
        end else if (i_s5_wr) begin
            wd5_q <= i_mem_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= ST_IDLE;
            wait_q           <= '0;
            o_mem_addr       <= '0;
            o_mem_space      <= MEM_SP_IRAM;
            o_mem_rd         <= 1'b0;
            o_mem_wr         <= 1'b0;
            o_mem_wdata      <= '0;
            o_s2_data_buffer <= '0;
            o_s3_data_buffer <= '0;
            o_bus_err        <= 1'b0;
        end else begin
            o_bus_err <= e5 || e2 || e3;
            case (state_q)
                ST_IDLE: begin
                    wait_q <= '0;
                    if (code5) begin
                        o_bus_err <= 1'b1;
                    end else if (hit2) begin
                        o_s2_data_buffer <= wd5_q;
                    end else if (hit3) begin
                        o_s3_data_buffer <= wd5_q;
                    end else if (p5) begin
                        state_q     <= ST_WR5;
                        o_mem_wr    <= 1'b1;
                        o_mem_addr  <= a5;
                        o_mem_space <= sp5;
                        o_mem_wdata <= wd5_q;
                    end else if (p2) begin
                        state_q     <= ST_RD2;
                        o_mem_rd    <= 1'b1;
                        o_mem_addr  <= a2;
                        o_mem_space <= sp2;
                    end else if (p3) begin
                        state_q     <= ST_RD3;
                        o_mem_rd    <= 1'b1;
                        o_mem_addr  <= a3;
                        o_mem_space <= sp3;
                    end
                end
                ST_WR5, ST_RD2, ST_RD3: begin
                    if (acc_end) begin
                        state_q  <= ST_DONE;
                        o_mem_rd <= 1'b0;
                        o_mem_wr <= 1'b0;
                        // ready wins over a coincident timeout
                        if (!i_mem_ready) o_bus_err <= 1'b1;
                        if (state_q == ST_RD2) o_s2_data_buffer <= i_mem_ready ? i_mem_rdata : '1;
                        if (state_q == ST_RD3) o_s3_data_buffer <= i_mem_ready ? i_mem_rdata : '1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
